alu_exec_unit: RTL

- Execute-stage ALU of the pipelined RV32 core. It sits directly downstream of the ALU decoder and consumes the 3-bit ALUControl code with the two operands.
- Produces a registered ALUResult and Zero flag behind a valid/ready handshake, so the EX stage can stall on back-pressure.
- Ops 000/001/010/011/101 are single-cycle. An optional iterative multiply is multi-cycle.

---
 rtl/alu_exec_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a registered result behind a valid/ready handshake.
// Optional iterative shift-add multiply (ALUControl 110) enabled by ALU_EXEC_MUL_EN.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t           state;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] alu_value;

    // The output register may be refilled in the same cycle it drains.
    assign can_load = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && !flush && can_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_value = '0;
        case (ALUControl)
            3'b000:  alu_value = SrcA + SrcB;
            3'b001:  alu_value = SrcA - SrcB;
            3'b010:  alu_value = SrcA & SrcB;
            3'b011:  alu_value = SrcA | SrcB;
            3'b101:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_value = '0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    mul_count;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] mul_final;
    logic             mul_last;
    logic             mul_done;

    assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_last  = (mul_count == CW'(WIDTH - 1));
    assign mul_done  = (mul_count == CW'(WIDTH));
    // Once all steps are in the accumulator the product waits there for the output slot.
    assign mul_final = mul_done ? mul_acc : mul_sum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            ALUResult  <= '0;
            Zero       <= 1'b1;
`ifdef ALU_EXEC_MUL_EN
            mul_count  <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
`endif
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mul_count <= '0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_EXEC_MUL_EN
                        if (ALUControl == 3'b110) begin
                            state      <= MUL_BUSY;
                            mul_count  <= '0;
                            mul_acc    <= '0;
                            mul_mcand  <= SrcA;
                            mul_mplier <= SrcB;
                        end else begin
                            ALUResult <= alu_value;
                            Zero      <= (alu_value == '0);
                            out_valid <= 1'b1;
                        end
`else
                        ALUResult <= alu_value;
                        Zero      <= (alu_value == '0);
                        out_valid <= 1'b1;
`endif
                    end
                end
                MUL_BUSY: begin
`ifdef ALU_EXEC_MUL_EN
                    if (!mul_done) begin
                        mul_acc    <= mul_sum;
                        mul_mcand  <= mul_mcand << 1;
                        mul_mplier <= mul_mplier >> 1;
                        mul_count  <= mul_count + 1'b1;
                    end
                    if ((mul_last || mul_done) && can_load) begin
                        ALUResult <= mul_final;
                        Zero      <= (mul_final == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                        mul_count <= '0;
                    end
`else
                    state <= IDLE;
`endif
                end
            endcase
        end
    end

endmodule
